// File: rtl/mac_sequencer.sv
// Sequencer that walks the filter datapath through N_TERMS multiply-accumulate
// terms for each new sample, then strobes the result and shifts the delay line.
module mac_sequencer #(
    parameter int          N_TERMS = 5,
    parameter int          MUL_LAT = 1,
    parameter logic [15:0] FUN_MAP = 16'h0140
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Bandera,
    input  logic       clr_ovr,
    output logic [2:0] sel_const,
    output logic [1:0] sel_fun,
    output logic       sel_acum,
    output logic       en_acum,
    output logic       en_shift,
    output logic       Band_Listo,
    output logic       busy,
    output logic       overrun
);

    generate
        if (N_TERMS < 2 || N_TERMS > 8 || MUL_LAT < 0 || MUL_LAT > 15) begin : g_bad_param
            $error("mac_sequencer: N_TERMS must be 2..8 and MUL_LAT 0..15");
        end
    endgenerate

    localparam logic [3:0] LAT  = 4'(MUL_LAT);
    localparam logic [2:0] LAST = 3'(N_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TERM,
        S_DONE
    } state_t;

    state_t     r_state, w_state_next;
    logic [2:0] r_k, w_k_next;
    logic [3:0] r_w, w_w_next;
    logic       r_pending, w_pending_next;
    logic       r_overrun, w_overrun_next;
    logic       r_bq;
    logic       w_edge;

    assign w_edge = Bandera & ~r_bq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_k       <= 3'd0;
            r_w       <= 4'd0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_bq      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_k       <= w_k_next;
            r_w       <= w_w_next;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
            r_bq      <= Bandera;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_k_next       = r_k;
        w_w_next       = r_w;
        w_pending_next = r_pending;
        // Clear first so that a new overrun in the same cycle takes priority.
        w_overrun_next = r_overrun & ~clr_ovr;
        sel_const      = 3'd0;
        sel_fun        = 2'd0;
        sel_acum       = 1'b0;
        en_acum        = 1'b0;
        en_shift       = 1'b0;
        Band_Listo     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_next = S_TERM;
                    w_k_next     = 3'd0;
                    w_w_next     = 4'd0;
                end
            end
            S_TERM: begin
                sel_const = r_k;
                sel_fun   = FUN_MAP[{r_k, 1'b0} +: 2];
                sel_acum  = (r_k != 3'd0);
                en_acum   = (r_w == LAT);
                if (r_w < LAT) begin
                    w_w_next = r_w + 4'd1;
                end else if (r_k < LAST) begin
                    w_k_next = r_k + 3'd1;
                    w_w_next = 4'd0;
                end else begin
                    w_state_next = S_DONE;
                end
                // Only one sample can wait behind the running one.
                if (w_edge) begin
                    if (r_pending) w_overrun_next = 1'b1;
                    else           w_pending_next = 1'b1;
                end
            end
            S_DONE: begin
                en_shift   = 1'b1;
                Band_Listo = 1'b1;
                w_k_next   = 3'd0;
                w_w_next   = 4'd0;
                w_state_next   = (r_pending || w_edge) ? S_TERM : S_IDLE;
                w_pending_next = r_pending & w_edge;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: default instance plus an N_TERMS=2,
// MUL_LAT=0 instance, checked by a monitor that pops expected outputs.
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] band = 2'b00;
    logic [1:0] clr = 2'b00;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic [2:0] sc0, sc1;
    logic [1:0] sf0, sf1;
    logic       sa0, sa1, ea0, ea1, sh0, sh1, bl0, bl1, bz0, bz1, ov0, ov1;
    logic [9:0] outv [2];
    logic       ovr  [2];
    logic [9:0] exp_v;

    int         bl_q [2][$];
    logic [9:0] tr_q [2][$];

    mac_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .Bandera(band[0]), .clr_ovr(clr[0]),
        .sel_const(sc0), .sel_fun(sf0), .sel_acum(sa0), .en_acum(ea0),
        .en_shift(sh0), .Band_Listo(bl0), .busy(bz0), .overrun(ov0)
    );

    mac_sequencer #(.N_TERMS(2), .MUL_LAT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .Bandera(band[1]), .clr_ovr(clr[1]),
        .sel_const(sc1), .sel_fun(sf1), .sel_acum(sa1), .en_acum(ea1),
        .en_shift(sh1), .Band_Listo(bl1), .busy(bz1), .overrun(ov1)
    );

    assign outv[0] = {sc0, sf0, sa0, ea0, sh0, bl0, bz0};
    assign outv[1] = {sc1, sf1, sa1, ea1, sh1, bl1, bz1};
    assign ovr[0]  = ov0;
    assign ovr[1]  = ov1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [9:0] mk(input int k, input int f, input bit sa, input bit ea,
                                      input bit sh, input bit bl, input bit bz);
        return {3'(k), 2'(f), sa, ea, sh, bl, bz};
    endfunction

    // Monitor: compares queued per-cycle traces and every Band_Listo pulse.
    always @(negedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (tr_q[d].size() > 0) begin
                exp_v = tr_q[d].pop_front();
                chk($sformatf("trace_dut%0d", d), 32'(outv[d]), 32'(exp_v));
            end
            if (outv[d][1]) begin
                if (bl_q[d].size() == 0) chk($sformatf("unexpected_listo_dut%0d", d), 1, 0);
                else chk($sformatf("listo_cycle_dut%0d", d), cyc, bl_q[d].pop_front());
            end
        end
    end

    // Called at a negedge: Bandera high for exactly one cycle.
    task automatic pulse(input int d);
        band[d] = 1'b1;
        @(negedge clk);
        band[d] = 1'b0;
    endtask

    task automatic push_default_trace();
        for (int i = 1; i <= 10; i++) begin
            tr_q[0].push_back(mk((i - 1) / 2, ((i - 1) / 2 >= 3) ? 1 : 0,
                                 ((i - 1) / 2) != 0, (i % 2) == 0, 1'b0, 1'b0, 1'b1));
        end
        tr_q[0].push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        tr_q[0].push_back(10'd0);
    endtask

    initial begin
        int c;
        #3;
        chk("reset_outputs_dut0", {21'd0, outv[0], ovr[0]}, 0);
        chk("reset_outputs_dut1", {21'd0, outv[1], ovr[1]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single one-cycle pulse: full cycle-by-cycle trace.
        c = cyc;
        bl_q[0].push_back(c + 11);
        pulse(0);
        push_default_trace();
        repeat (15) @(negedge clk);

        // Bandera held high: one sequence only.
        c = cyc;
        bl_q[0].push_back(c + 11);
        band[0] = 1'b1;
        repeat (20) @(negedge clk);
        band[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_high_single_listo", bl_q[0].size(), 0);

        // Second edge at cycle 5 becomes pending, restart with no idle.
        c = cyc;
        bl_q[0].push_back(c + 11);
        bl_q[0].push_back(c + 22);
        pulse(0);
        repeat (4) @(negedge clk);
        pulse(0);
        repeat (25) @(negedge clk);
        #1;
        chk("pending_no_overrun", ovr[0], 0);
        chk("pending_two_listo", bl_q[0].size(), 0);

        // Edges at cycles 3 and 6: second one overruns and is lost.
        @(negedge clk);
        c = cyc;
        bl_q[0].push_back(c + 11);
        bl_q[0].push_back(c + 22);
        pulse(0);
        repeat (2) @(negedge clk);
        pulse(0);
        repeat (2) @(negedge clk);
        pulse(0);
        repeat (25) @(negedge clk);
        #1;
        chk("overrun_set", ovr[0], 1);
        chk("overrun_two_listo", bl_q[0].size(), 0);
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        #1;
        chk("overrun_cleared", ovr[0], 0);

        // Short configuration, edge in the DONE cycle restarts immediately.
        @(negedge clk);
        c = cyc;
        bl_q[1].push_back(c + 3);
        bl_q[1].push_back(c + 6);
        pulse(1);
        for (int r = 0; r < 2; r++) begin
            tr_q[1].push_back(mk(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
            tr_q[1].push_back(mk(1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
            tr_q[1].push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        end
        tr_q[1].push_back(10'd0);
        repeat (2) @(negedge clk);
        pulse(1);
        repeat (8) @(negedge clk);
        chk("short_cfg_two_listo", bl_q[1].size(), 0);

        // Asynchronous reset mid-sequence, then a clean sequence.
        pulse(0);
        repeat (3) @(negedge clk);
        #1;
        chk("busy_before_abort", outv[0][0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {21'd0, outv[0], ovr[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        c = cyc;
        bl_q[0].push_back(c + 11);
        pulse(0);
        push_default_trace();
        repeat (15) @(negedge clk);

        chk("listo_queue_dut0_empty", bl_q[0].size(), 0);
        chk("trace_queue_dut0_empty", tr_q[0].size(), 0);
        chk("trace_queue_dut1_empty", tr_q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
